// File: rtl/router_pkg.sv
// Shared types and helpers for the clocked mesh router: port and packet-type
// enums, a node-coordinate struct, and the XY-routing / replication functions.
package router_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_UP    = 3'd0,
        PORT_DOWN  = 3'd1,
        PORT_LEFT  = 3'd2,
        PORT_RIGHT = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        PKT_FILTER = 2'b00,
        PKT_IFMAP  = 2'b01,
        PKT_PSUM   = 2'b10,
        PKT_OTHER  = 2'b11
    } pkt_type_e;

    // Coordinates are carried at a fixed 16-bit width so the helpers stay
    // independent of the AX/AY parameters of any particular router instance.
    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } node_addr_t;

    // Pull a right-aligned field of 'width' bits starting at 'lsb'.
    function automatic logic [15:0] field_extract(input logic [63:0] word,
                                                  input int          lsb,
                                                  input int          width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 16'((word >> lsb) & mask);
    endfunction

    // X-first dimension-ordered routing.
    function automatic port_e route_xy(input node_addr_t dst, input node_addr_t here);
        if (dst == here)        return PORT_LOCAL;
        if (dst.x > here.x)     return PORT_RIGHT;
        if (dst.x < here.x)     return PORT_LEFT;
        if (dst.y > here.y)     return PORT_DOWN;
        return PORT_UP;
    endfunction

    // Destination of the forwarded copy: filters move one row down the column,
    // ifmaps move diagonally (one column right, one row up).
    function automatic node_addr_t mcast_rewrite(input pkt_type_e typ, input node_addr_t dst);
        node_addr_t nxt;
        nxt = dst;
        if (typ == PKT_FILTER) begin
            nxt.y = dst.y + 16'd1;
        end else if (typ == PKT_IFMAP) begin
            nxt.x = dst.x + 16'd1;
            nxt.y = dst.y - 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO used as the per-input buffer. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage array: written on an accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO by realigning both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesh_router_sync.sv
// Five-port clocked mesh router: per-input FIFOs, XY routing, per-output
// round-robin arbitration, registered outputs, and optional two-phase
// replication of filter/ifmap packets addressed to this node.
module mesh_router_sync
    import router_pkg::*;
#(
    parameter int WIDTH_PKT  = 32,
    parameter int AX         = 3,
    parameter int AY         = 5,
    parameter int ADDRX      = 0,
    parameter int ADDRY      = 0,
    parameter int DEPTH_R    = 21,
    parameter int DEPTH_F    = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int EN_MCAST   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                in_valid,
    output logic [NUM_PORTS-1:0]                in_ready,
    input  logic [NUM_PORTS-1:0][WIDTH_PKT-1:0] in_data,
    output logic [NUM_PORTS-1:0]                out_valid,
    input  logic [NUM_PORTS-1:0]                out_ready,
    output logic [NUM_PORTS-1:0][WIDTH_PKT-1:0] out_data
);

    localparam int TYPE_LSB = WIDTH_PKT - 3;
    localparam int Y_LSB    = TYPE_LSB - AY;
    localparam int X_LSB    = Y_LSB - AX;

    localparam node_addr_t HERE = '{y: 16'(ADDRY), x: 16'(ADDRX)};

    // Edge-of-array nodes have no neighbour to forward a copy to.
    localparam bit FILTER_OK = (EN_MCAST != 0) && (ADDRY != DEPTH_R - 1);
    localparam bit IFMAP_OK  = (EN_MCAST != 0) && (ADDRY != 0) && (ADDRX != DEPTH_F - 1);

    logic [NUM_PORTS-1:0]                fifo_full;
    logic [NUM_PORTS-1:0]                fifo_empty;
    logic [NUM_PORTS-1:0]                fifo_push;
    logic [NUM_PORTS-1:0]                fifo_pop;
    logic [NUM_PORTS-1:0][WIDTH_PKT-1:0] fifo_head;

    logic [NUM_PORTS-1:0]                head_mcast;
    logic [NUM_PORTS-1:0]                copy_flag;
    logic [NUM_PORTS-1:0][WIDTH_PKT-1:0] eff_data;
    port_e                               head_route [NUM_PORTS];

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_mat;
    logic [NUM_PORTS-1:0]                load_en;
    logic [NUM_PORTS-1:0]                grant_any;
    logic [NUM_PORTS-1:0][2:0]           win_idx;
    logic [NUM_PORTS-1:0]                in_grant;

    assign in_ready  = ~fifo_full & {NUM_PORTS{~rst}};
    assign fifo_push = in_valid & in_ready;
    assign load_en   = ~out_valid | out_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        router_fifo #(
            .WIDTH (WIDTH_PKT),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .wdata (in_data[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .head  (fifo_head[i])
        );
    end

    // Decode each FIFO head: replication eligibility, the packet actually
    // offered this cycle (original, or rewritten copy in the second phase),
    // and the output it routes to.
    always_comb begin
        pkt_type_e  head_type;
        node_addr_t head_dst;
        node_addr_t copy_dst;
        node_addr_t eff_dst;
        head_type = PKT_FILTER;
        head_dst  = '0;
        copy_dst  = '0;
        eff_dst   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            head_type  = pkt_type_e'(fifo_head[i][TYPE_LSB +: 2]);
            head_dst.y = field_extract(64'(fifo_head[i]), Y_LSB, AY);
            head_dst.x = field_extract(64'(fifo_head[i]), X_LSB, AX);
            head_mcast[i] = (head_dst == HERE) &&
                            (((head_type == PKT_FILTER) && FILTER_OK) ||
                             ((head_type == PKT_IFMAP)  && IFMAP_OK));
            eff_data[i] = fifo_head[i];
            if (head_mcast[i] && copy_flag[i]) begin
                copy_dst = mcast_rewrite(head_type, head_dst);
                eff_data[i][Y_LSB +: AY] = copy_dst.y[AY-1:0];
                eff_data[i][X_LSB +: AX] = copy_dst.x[AX-1:0];
            end
            eff_dst.y     = field_extract(64'(eff_data[i]), Y_LSB, AY);
            eff_dst.x     = field_extract(64'(eff_data[i]), X_LSB, AX);
            head_route[i] = route_xy(eff_dst, HERE);
        end
    end

    // Request matrix indexed [output][input]; each non-empty input asks for one output.
    always_comb begin
        req_mat = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_mat[o][i] = !fifo_empty[i] && (3'(head_route[i]) == 3'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        logic [2:0] rr_ptr;
        logic       found;
        logic [2:0] pick;

        // Round-robin search starting at rr_ptr, only when the output register can take a packet.
        always_comb begin
            int idx;
            found = 1'b0;
            pick  = 3'd0;
            idx   = 0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!found && load_en[o] && req_mat[o][idx]) begin
                    found = 1'b1;
                    pick  = 3'(idx);
                end
            end
        end

        // Priority moves to the input just after the winner.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr <= 3'd0;
            end else if (found) begin
                rr_ptr <= (pick == 3'(NUM_PORTS - 1)) ? 3'd0 : pick + 3'd1;
            end
        end

        assign grant_any[o] = found;
        assign win_idx[o]   = pick;
    end

    // Fold output grants back onto inputs; the first phase of a replicated head keeps it in the FIFO.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_any[o]) begin
                in_grant[win_idx[o]] = 1'b1;
            end
        end
        fifo_pop = in_grant & ~(head_mcast & ~copy_flag);
    end

    // Output registers hold until accepted; copy flags track the replication phase per input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            copy_flag <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant_any[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= eff_data[win_idx[o]];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (in_grant[i]) begin
                    copy_flag[i] <= head_mcast[i] && !copy_flag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_router_sync.sv
// Directed bench for mesh_router_sync: a router at node (X=2,Y=13) plus an
// edge-of-array router at (X=4,Y=20) where replication must be suppressed.
module tb_mesh_router_sync;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    logic [4:0]        in_valid;
    logic [4:0]        in_ready;
    logic [4:0][W-1:0] in_data;
    logic [4:0]        out_valid;
    logic [4:0]        out_ready;
    logic [4:0][W-1:0] out_data;

    logic [4:0]        e_in_valid;
    logic [4:0]        e_in_ready;
    logic [4:0][W-1:0] e_in_data;
    logic [4:0]        e_out_valid;
    logic [4:0]        e_out_ready;
    logic [4:0][W-1:0] e_out_data;

    int check_count = 0;
    int error_count = 0;

    logic [W-1:0] pkt;
    logic [W-1:0] e_pkt;

    always #5 clk = ~clk;

    mesh_router_sync #(
        .WIDTH_PKT (W), .AX (3), .AY (5), .ADDRX (2), .ADDRY (13),
        .DEPTH_R (21), .DEPTH_F (5), .FIFO_DEPTH (4), .EN_MCAST (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    mesh_router_sync #(
        .WIDTH_PKT (W), .AX (3), .AY (5), .ADDRX (4), .ADDRY (20),
        .DEPTH_R (21), .DEPTH_F (5), .FIFO_DEPTH (4), .EN_MCAST (1)
    ) dut_edge (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_data   (e_in_data),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_data  (e_out_data)
    );

    function automatic logic [W-1:0] mk_pkt(input logic [1:0] typ, input logic [4:0] y,
                                           input logic [2:0] x, input logic [20:0] payload);
        return {1'b0, typ, y, x, payload};
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [W-1:0] data);
        in_valid[port] = 1'b1;
        in_data[port]  = data;
    endtask

    task automatic clear_inputs();
        in_valid   = '0;
        e_in_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = '1;
        e_in_valid  = '0;
        e_in_data   = '0;
        e_out_ready = '1;

        // Reset state
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_out_data_right", out_data[3], 32'h0);
        checkOutput("reset_edge_in_ready", 32'(e_in_ready), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'h1f);

        // Unicast to the right and to local
        $display("[TB] unicast");
        pkt = mk_pkt(2'b10, 5'd13, 3'd4, 21'h57);
        applyStimulus(0, pkt);
        tick();
        clear_inputs();
        checkOutput("uni_not_yet", 32'(out_valid), 32'h0);
        tick();
        checkOutput("uni_right_valid", 32'(out_valid), 32'h08);
        checkOutput("uni_right_data", out_data[3], pkt);
        tick();
        checkOutput("uni_right_drained", 32'(out_valid), 32'h0);
        pkt = mk_pkt(2'b10, 5'd13, 3'd2, 21'h58);
        applyStimulus(0, pkt);
        tick();
        clear_inputs();
        tick();
        checkOutput("uni_local_valid", 32'(out_valid), 32'h10);
        checkOutput("uni_local_data", out_data[4], pkt);
        tick();
        checkOutput("uni_local_only", 32'(out_valid), 32'h0);

        // Filter replication; edge node at Y=20 delivers locally only
        $display("[TB] filter multicast");
        pkt   = mk_pkt(2'b00, 5'd13, 3'd2, 21'h123);
        e_pkt = mk_pkt(2'b00, 5'd20, 3'd4, 21'h124);
        applyStimulus(1, pkt);
        e_in_valid[1] = 1'b1;
        e_in_data[1]  = e_pkt;
        tick();
        clear_inputs();
        tick();
        checkOutput("flt_local_valid", 32'(out_valid), 32'h10);
        checkOutput("flt_local_data", out_data[4], pkt);
        checkOutput("flt_edge_local_valid", 32'(e_out_valid), 32'h10);
        checkOutput("flt_edge_local_data", e_out_data[4], e_pkt);
        tick();
        checkOutput("flt_copy_valid", 32'(out_valid), 32'h02);
        checkOutput("flt_copy_data", out_data[1], mk_pkt(2'b00, 5'd14, 3'd2, 21'h123));
        checkOutput("flt_edge_no_copy", 32'(e_out_valid), 32'h0);
        tick();
        checkOutput("flt_done", 32'(out_valid), 32'h0);

        // Ifmap replication; edge node at X=4 delivers locally only
        $display("[TB] ifmap multicast");
        pkt   = mk_pkt(2'b01, 5'd13, 3'd2, 21'hABC);
        e_pkt = mk_pkt(2'b01, 5'd20, 3'd4, 21'hABD);
        applyStimulus(0, pkt);
        e_in_valid[0] = 1'b1;
        e_in_data[0]  = e_pkt;
        tick();
        clear_inputs();
        tick();
        checkOutput("ifm_local_valid", 32'(out_valid), 32'h10);
        checkOutput("ifm_local_data", out_data[4], pkt);
        checkOutput("ifm_edge_local_data", e_out_data[4], e_pkt);
        tick();
        checkOutput("ifm_copy_valid", 32'(out_valid), 32'h08);
        checkOutput("ifm_copy_data", out_data[3], mk_pkt(2'b01, 5'd12, 3'd3, 21'hABC));
        checkOutput("ifm_edge_no_copy", 32'(e_out_valid), 32'h0);
        tick();
        checkOutput("ifm_done", 32'(out_valid), 32'h0);

        // Contention on the right output from fresh RR pointers; the second
        // round repeats the same order only if the pointer wrapped back to up.
        $display("[TB] contention");
        do_reset();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h100 + r * 16 + 1)));
            applyStimulus(2, mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h100 + r * 16 + 2)));
            applyStimulus(4, mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h100 + r * 16 + 3)));
            tick();
            clear_inputs();
            for (int n = 1; n <= 3; n++) begin
                tick();
                checkOutput($sformatf("rr_r%0d_valid%0d", r, n), 32'(out_valid), 32'h08);
                checkOutput($sformatf("rr_r%0d_data%0d", r, n), out_data[3],
                            mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h100 + r * 16 + n)));
            end
            tick();
            checkOutput($sformatf("rr_r%0d_idle", r), 32'(out_valid), 32'h0);
        end

        // Backpressure on the right output
        $display("[TB] backpressure");
        out_ready[3] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("bp_ready_before%0d", n), 32'(in_ready[2]), 32'h1);
            applyStimulus(2, mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h200 + n)));
            tick();
        end
        clear_inputs();
        checkOutput("bp_full_ready", 32'(in_ready[2]), 32'h0);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'h08);
        checkOutput("bp_hold_data", out_data[3], mk_pkt(2'b10, 5'd13, 3'd4, 21'h200));
        tick();
        tick();
        checkOutput("bp_stable_data", out_data[3], mk_pkt(2'b10, 5'd13, 3'd4, 21'h200));
        checkOutput("bp_still_full", 32'(in_ready[2]), 32'h0);
        out_ready[3] = 1'b1;
        #1;
        checkOutput("bp_pop_cycle_ready", 32'(in_ready[2]), 32'h0);
        tick();
        checkOutput("bp_ready_after_pop", 32'(in_ready[2]), 32'h1);
        checkOutput("bp_drain1", out_data[3], mk_pkt(2'b10, 5'd13, 3'd4, 21'h201));
        for (int n = 2; n < 5; n++) begin
            tick();
            checkOutput($sformatf("bp_drain%0d_valid", n), 32'(out_valid), 32'h08);
            checkOutput($sformatf("bp_drain%0d", n), out_data[3],
                        mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h200 + n)));
        end
        tick();
        checkOutput("bp_drained", 32'(out_valid), 32'h0);

        // Reset with packets in flight
        $display("[TB] reset mid-traffic");
        out_ready[3] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2, mk_pkt(2'b10, 5'd13, 3'd4, 21'(32'h300 + n)));
            tick();
        end
        clear_inputs();
        checkOutput("mid_pending_valid", 32'(out_valid), 32'h08);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        out_ready = '1;
        tick();
        checkOutput("mid_post_in_ready", 32'(in_ready), 32'h1f);
        checkOutput("mid_post_valid0", 32'(out_valid), 32'h0);
        tick();
        tick();
        checkOutput("mid_post_valid2", 32'(out_valid), 32'h0);
        pkt = mk_pkt(2'b11, 5'd13, 3'd0, 21'h77);
        applyStimulus(0, pkt);
        tick();
        clear_inputs();
        checkOutput("mid_new_latency", 32'(out_valid), 32'h0);
        tick();
        checkOutput("mid_new_left_valid", 32'(out_valid), 32'h04);
        checkOutput("mid_new_left_data", out_data[2], pkt);
        tick();
        checkOutput("mid_new_done", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
